// File: rtl/hex_display_pkg.sv
// Shared seven-segment decode table and helpers for the hex display controller.
// Patterns are active-high, bit order g..a (bit 0 = segment a).
package hex_display_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  // Index 15 comes first in the concatenation, so entry n is the glyph for hex digit n.
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h67, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

  function automatic logic [SEG_W-1:0] to_polarity(input logic [SEG_W-1:0] pat,
                                                   input logic            active_low);
    return active_low ? ~pat : pat;
  endfunction

endpackage

// File: rtl/hex_display_ctrl_scan_timer.sv
// Scan prescaler, scan digit index and blink phase generator for hex_display_ctrl.
// One tick every SCAN_DIV cycles advances the scanned digit; BLINK_TICKS ticks flip the blink phase.
module hex_scan_timer #(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int BLINK_TICKS = 250,
  parameter int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [IDX_W-1:0] scan_idx_o,
  output logic             blink_phase_o
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_TICKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0] div_cnt_q,     div_cnt_d;
  logic [IDX_W-1:0] scan_idx_q,    scan_idx_d;
  logic [BLK_W-1:0] blink_cnt_q,   blink_cnt_d;
  logic             blink_phase_q, blink_phase_d;
  logic             tick;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    tick          = (div_cnt_q == DIV_LAST);
    div_cnt_d     = div_cnt_q + 1'b1;
    scan_idx_d    = scan_idx_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;

    if (tick) begin
      div_cnt_d = '0;

      if (scan_idx_q == IDX_LAST) scan_idx_d = '0;
      else                        scan_idx_d = scan_idx_q + 1'b1;

      if (blink_cnt_q == BLK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
    if (rst) begin
      div_cnt_q     <= '0;
      scan_idx_q    <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      scan_idx_q    <= scan_idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign scan_idx_o    = scan_idx_q;
  assign blink_phase_o = blink_phase_q;

endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-digit hex seven-segment controller: parallel per-digit outputs plus a scanned mux bus,
// with leading-zero blanking, per-digit blink, global enable and selectable output polarity.
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int BLINK_TICKS = 250,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic                    blank_lz_i,
  input  logic [NUM_DIGITS-1:0]   blink_mask_i,
  input  logic                    enable_i,
  output logic [7*NUM_DIGITS-1:0] seg_o,
  output logic [6:0]              seg_mux_o,
  output logic [NUM_DIGITS-1:0]   an_o
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [SEG_W-1:0]      SEG_OFF = to_polarity(SEG_BLANK, ACTIVE_LOW);
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{ACTIVE_LOW}};

  logic [4*NUM_DIGITS-1:0] value_q,   value_d;
  logic [NUM_DIGITS-1:0]   blink_q,   blink_d;
  logic [7*NUM_DIGITS-1:0] seg_q,     seg_d;
  logic [SEG_W-1:0]        seg_mux_q, seg_mux_d;
  logic [NUM_DIGITS-1:0]   an_q,      an_d;

  logic [IDX_W-1:0]        scan_idx;
  logic                    blink_phase;
  logic [NUM_DIGITS-1:0]   upper_zero;
  logic [NUM_DIGITS-1:0]   blank;
  logic [NUM_DIGITS-1:0]   an_hot;
  logic                    zero_run;

  hex_scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .SCAN_DIV    (SCAN_DIV),
    .BLINK_TICKS (BLINK_TICKS),
    .IDX_W       (IDX_W)
  ) u_scan_timer (
    .clk           (clk),
    .rst           (rst),
    .scan_idx_o    (scan_idx),
    .blink_phase_o (blink_phase)
  );

  always_comb begin
    value_d = load_i ? value_i : value_q;
    blink_d = load_i ? blink_mask_i : blink_q;
  end

  // upper_zero[i]: digit i and every digit above it are zero.
  always_comb begin
    zero_run   = 1'b1;
    upper_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run && (value_q[4*i +: 4] == 4'h0);
      upper_zero[i] = zero_run;
    end
  end

  always_comb begin
    blank = '0;
    seg_d = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      blank[i] = !enable_i
              || (blink_phase && blink_q[i])
              || (blank_lz_i && upper_zero[i] && (i > 0));
      seg_d[7*i +: 7] = to_polarity(blank[i] ? SEG_BLANK : seg_decode(value_q[4*i +: 4]),
                                    ACTIVE_LOW);
    end
  end

  // The scanned digit reuses the already-blanked parallel pattern, so both buses always agree.
  always_comb begin
    seg_mux_d = SEG_OFF;
    an_hot    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == scan_idx) begin
        seg_mux_d = seg_d[7*i +: 7];
        an_hot[i] = enable_i;
      end
    end
    an_d = ACTIVE_LOW ? ~an_hot : an_hot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q   <= '0;
      blink_q   <= '0;
      seg_q     <= {NUM_DIGITS{SEG_OFF}};
      seg_mux_q <= SEG_OFF;
      an_q      <= AN_OFF;
    end else begin
      value_q   <= value_d;
      blink_q   <= blink_d;
      seg_q     <= seg_d;
      seg_mux_q <= seg_mux_d;
      an_q      <= an_d;
    end
  end

  assign seg_o     = seg_q;
  assign seg_mux_o = seg_mux_q;
  assign an_o      = an_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Scoreboard bench for hex_display_ctrl: a 4-digit active-low instance and a 1-digit active-high
// instance share stimulus; a time-based reference model predicts every output cycle by cycle.
module tb_hex_display_ctrl;

  typedef struct packed {
    logic [55:0] seg;
    logic [6:0]  mux;
    logic [7:0]  an;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        load_i;
  logic [15:0] value_i;
  logic        blank_lz_i;
  logic [3:0]  blink_mask_i;
  logic        enable_i;

  logic [27:0] seg_a;
  logic [6:0]  mux_a;
  logic [3:0]  an_a;
  logic [6:0]  seg_b;
  logic [6:0]  mux_b;
  logic [0:0]  an_b;

  int checks   = 0;
  int failures = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  logic [31:0] m_val;
  logic [7:0]  m_mask;
  int          k;

  logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  hex_display_ctrl #(
    .NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_TICKS(2), .ACTIVE_LOW(1)
  ) dut_a (
    .clk(clk), .rst(rst), .load_i(load_i), .value_i(value_i),
    .blank_lz_i(blank_lz_i), .blink_mask_i(blink_mask_i), .enable_i(enable_i),
    .seg_o(seg_a), .seg_mux_o(mux_a), .an_o(an_a)
  );

  hex_display_ctrl #(
    .NUM_DIGITS(1), .SCAN_DIV(3), .BLINK_TICKS(1), .ACTIVE_LOW(0)
  ) dut_b (
    .clk(clk), .rst(rst), .load_i(load_i), .value_i(value_i[3:0]),
    .blank_lz_i(blank_lz_i), .blink_mask_i(blink_mask_i[0:0]), .enable_i(enable_i),
    .seg_o(seg_b), .seg_mux_o(mux_b), .an_o(an_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected registered outputs after an edge that is k edges past the last reset edge.
  // Scan position and blink phase follow directly from elapsed time; outputs lag the timer by one edge.
  function automatic exp_t model(int nd, bit al, int sd, int bt, logic [31:0] val,
                                 logic [7:0] mask, bit en, bit lz, int kk, bit in_rst);
    exp_t        e;
    int          idx;
    bit          phase;
    logic [6:0]  pat;
    logic [31:0] v;
    e     = '0;
    v     = (nd == 8) ? val : (val & ((32'd1 << (4*nd)) - 32'd1));
    idx   = in_rst ? 0 : ((kk - 1) / sd) % nd;
    phase = in_rst ? 1'b0 : ((((kk - 1) / (sd * bt)) % 2) == 1);
    for (int i = 0; i < nd; i++) begin
      bit blk;
      blk = in_rst || !en || (phase && mask[i]) || (lz && i > 0 && (v >> (4*i)) == 0);
      pat = blk ? 7'h00 : seg_tbl[v[4*i +: 4]];
      e.seg[7*i +: 7] = al ? ~pat : pat;
    end
    e.mux = e.seg[7*idx +: 7];
    for (int i = 0; i < nd; i++) begin
      bit b;
      b = !in_rst && en && (i == idx);
      e.an[i] = al ? ~b : b;
    end
    return e;
  endfunction

  task automatic drive(input bit r, input bit ld, input logic [15:0] v,
                       input logic [3:0] m, input bit en, input bit lz);
    @(negedge clk);
    rst          = r;
    load_i       = ld;
    value_i      = v;
    blink_mask_i = m;
    enable_i     = en;
    blank_lz_i   = lz;
    if (r) begin
      q_a.push_back(model(4, 1'b1, 4, 2, 32'd0, 8'd0, en, lz, 0, 1'b1));
      q_b.push_back(model(1, 1'b0, 3, 1, 32'd0, 8'd0, en, lz, 0, 1'b1));
      m_val  = '0;
      m_mask = '0;
      k      = 0;
    end else begin
      k++;
      q_a.push_back(model(4, 1'b1, 4, 2, m_val, m_mask, en, lz, k, 1'b0));
      q_b.push_back(model(1, 1'b0, 3, 1, m_val, m_mask, en, lz, k, 1'b0));
      if (ld) begin
        m_val  = {16'd0, v};
        m_mask = {4'd0, m};
      end
    end
  endtask

  task automatic idle(input int n, input bit en, input bit lz);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0000, 4'h0, en, lz);
  endtask

  // Monitors: pop one expectation per edge and compare once outputs have settled.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        check("a_seg", 64'(seg_a), 64'(e.seg));
        check("a_mux", 64'(mux_a), 64'(e.mux));
        check("a_an",  64'(an_a),  64'(e.an));
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        check("b_seg", 64'(seg_b), 64'(e.seg));
        check("b_mux", 64'(mux_b), 64'(e.mux));
        check("b_an",  64'(an_b),  64'(e.an));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] sweep [4];
    sweep = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
    rst = 1'b1; load_i = 1'b0; value_i = '0; blank_lz_i = 1'b0;
    blink_mask_i = '0; enable_i = 1'b1;
    m_val = '0; m_mask = '0; k = 0;

    drive(1'b1, 1'b0, 16'h0, 4'h0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 16'h0, 4'h0, 1'b1, 1'b0);
    idle(3, 1'b1, 1'b0);

    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, sweep[i], 4'h0, 1'b1, 1'b0);
      idle(3, 1'b1, 1'b0);
    end

    drive(1'b0, 1'b1, 16'h00A0, 4'h0, 1'b1, 1'b1);
    idle(3, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 16'h0000, 4'h0, 1'b1, 1'b1);
    idle(3, 1'b1, 1'b1);

    drive(1'b0, 1'b1, 16'h1234, 4'h0, 1'b1, 1'b0);
    idle(20, 1'b1, 1'b0);

    drive(1'b0, 1'b1, 16'h5A5A, 4'b0010, 1'b1, 1'b0);
    idle(20, 1'b1, 1'b0);
    idle(5, 1'b0, 1'b0);
    idle(20, 1'b1, 1'b0);

    idle(5, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 16'h0, 4'h0, 1'b1, 1'b0);
    idle(20, 1'b1, 1'b0);

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 5) == 0, 16'($urandom),
            4'($urandom), $urandom_range(0, 9) != 0, 1'($urandom));
    end
    drive(1'b0, 1'b0, 16'h0, 4'h0, 1'b1, 1'b0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(q_a.size() + q_b.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
